// File: rtl/alu_sched_pkg.sv
// Shared types and widths for the ALU request scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_sched_pkg;

  localparam int OP_W   = 2;
  localparam int DATA_W = 4;
  localparam int RES_W  = 5;
  localparam int ANS_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_req_scheduler_if.sv
// Request/response bundle between two command sources, their consumer and the scheduler.
// Latency: n/a (wires only).
// Backpressure: reqN_valid/reqN_ready per requester, rsp_valid/rsp_ready on the shared response.
// Ports: master = requesters + response consumer side, slave = scheduler side.
interface alu_req_scheduler_if;
  import alu_sched_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [RES_W-1:0]  rsp_result;
  logic [ANS_W-1:0]  rsp_answer;
  logic              rsp_eq;
  logic              rsp_less;
  logic              rsp_great;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_answer, rsp_eq, rsp_less, rsp_great
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_answer, rsp_eq, rsp_less, rsp_great
  );
endinterface

// File: rtl/alu_final.sv
// Team 4-bit combinational ALU: add, subtract, and, xor plus magnitude compare of A and B.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: op {A1,A0}, a, b in; result (bit 4 = carry/borrow), answer (low nibble), eq/less/great out.
module alu_final
  import alu_sched_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [RES_W-1:0]  result,
  output logic [ANS_W-1:0]  answer,
  output logic              eq,
  output logic              less,
  output logic              great
);

  always_comb begin
    result = '0;
    case (op)
      2'b00:   result = {1'b0, a} + {1'b0, b};
      // Bit 4 ends up as the borrow when a < b.
      2'b01:   result = {1'b0, a} - {1'b0, b};
      2'b10:   result = {1'b0, a & b};
      default: result = {1'b0, a ^ b};
    endcase
  end

  assign answer = result[ANS_W-1:0];
  assign eq     = (a == b);
  assign less   = (a < b);
  assign great  = (a > b);

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: grant selection plus next-pointer computation.
// Latency: 0 cycles (combinational; the caller owns the pointer register).
// Backpressure: none; the caller gates valid when it cannot accept.
// Ports: valid[1:0], ptr (current priority holder), accept -> grant[1:0] (one-hot or zero), ptr_nxt.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       ptr_nxt
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

  // Priority moves to whichever requester did not win, even a lone winner.
  assign ptr_nxt = accept ? grant[0] : ptr;

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one alu_final between two requesters, round-robin, one operation in flight.
// Latency: ready in cycle c -> rsp_valid in cycle c+2; 3 cycles minimum per operation.
// Backpressure: readys stay low while busy; the response is held until rsp_ready.
// Ports: clk, rst (sync, active high), bus (slave side of the interface), gnt_cnt0/1 (saturating).
module alu_req_scheduler #(
  parameter int DATA_W    = 4,
  parameter bit PRIO_INIT = 1'b0,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_req_scheduler_if.slave   bus,
  output logic [CNT_W-1:0]     gnt_cnt0,
  output logic [CNT_W-1:0]     gnt_cnt1
);
  import alu_sched_pkg::*;

  if (DATA_W != alu_sched_pkg::DATA_W) begin : g_bad_data_w
    $error("alu_req_scheduler: DATA_W must be 4 to match alu_final");
  end

  state_t            state_q;
  logic              ptr_q;
  logic              ptr_nxt;
  logic [1:0]        req_vld;
  logic [1:0]        gnt;
  logic              accept;
  logic              gnt_id;

  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              id_q;

  logic [RES_W-1:0]  alu_result;
  logic [ANS_W-1:0]  alu_answer;
  logic              alu_eq;
  logic              alu_less;
  logic              alu_great;

  logic              rsp_id_q;
  logic [RES_W-1:0]  rsp_result_q;
  logic [ANS_W-1:0]  rsp_answer_q;
  logic              rsp_eq_q;
  logic              rsp_less_q;
  logic              rsp_great_q;

  // Requests are only visible to the arbiter while idle, so no ready leaks out when busy.
  assign req_vld = (state_q == IDLE) ? {bus.req1_valid, bus.req0_valid} : 2'b00;

  rr_arb2 u_arb (
    .valid   (req_vld),
    .ptr     (ptr_q),
    .accept  (accept),
    .grant   (gnt),
    .ptr_nxt (ptr_nxt)
  );

  // A grant is only issued to a valid requester, so any grant is a transfer.
  assign accept         = |gnt;
  assign gnt_id         = gnt[1];
  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];

  alu_final u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .answer (alu_answer),
    .eq     (alu_eq),
    .less   (alu_less),
    .great  (alu_great)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= PRIO_INIT;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_answer_q <= '0;
      rsp_eq_q     <= 1'b0;
      rsp_less_q   <= 1'b0;
      rsp_great_q  <= 1'b0;
      gnt_cnt0     <= '0;
      gnt_cnt1     <= '0;
    end else begin
      ptr_q <= ptr_nxt;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= EXEC;
            id_q    <= gnt_id;
            op_q    <= gnt_id ? bus.req1_op : bus.req0_op;
            a_q     <= gnt_id ? bus.req1_a  : bus.req0_a;
            b_q     <= gnt_id ? bus.req1_b  : bus.req0_b;
            if (gnt[0] && (gnt_cnt0 != {CNT_W{1'b1}})) gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
            if (gnt[1] && (gnt_cnt1 != {CNT_W{1'b1}})) gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
          end
        end
        EXEC: begin
          state_q      <= RESP;
          rsp_id_q     <= id_q;
          rsp_result_q <= alu_result;
          rsp_answer_q <= alu_answer;
          rsp_eq_q     <= alu_eq;
          rsp_less_q   <= alu_less;
          rsp_great_q  <= alu_great;
        end
        RESP: begin
          if (bus.rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_answer = rsp_answer_q;
  assign bus.rsp_eq     = rsp_eq_q;
  assign bus.rsp_less   = rsp_less_q;
  assign bus.rsp_great  = rsp_great_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: directed scenarios plus randomized traffic against a behavioural model.
// Latency: n/a.
// Backpressure: randomized rsp_ready and requester withdrawals.
module tb_alu_req_scheduler;

  localparam bit PRIO_INIT = 1'b0;

  typedef struct packed {
    logic [4:0] result;
    logic [3:0] answer;
    logic       eq;
    logic       less;
    logic       great;
  } alu_out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  alu_req_scheduler_if bus();
  alu_req_scheduler_if bus_s();
  logic [7:0] gnt_cnt0, gnt_cnt1;
  logic [1:0] sat_cnt0, sat_cnt1;

  alu_req_scheduler #(.DATA_W(4), .PRIO_INIT(PRIO_INIT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  // Second copy with 2-bit counters sees identical traffic; only its counters are checked.
  alu_req_scheduler #(.DATA_W(4), .PRIO_INIT(PRIO_INIT), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus_s), .gnt_cnt0(sat_cnt0), .gnt_cnt1(sat_cnt1)
  );

  assign bus_s.req0_valid = bus.req0_valid;
  assign bus_s.req0_op    = bus.req0_op;
  assign bus_s.req0_a     = bus.req0_a;
  assign bus_s.req0_b     = bus.req0_b;
  assign bus_s.req1_valid = bus.req1_valid;
  assign bus_s.req1_op    = bus.req1_op;
  assign bus_s.req1_a     = bus.req1_a;
  assign bus_s.req1_b     = bus.req1_b;
  assign bus_s.rsp_ready  = bus.rsp_ready;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic alu_out_t alu_ref(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int ia, ib, r;
    alu_out_t o;
    ia = int'(a);
    ib = int'(b);
    case (op)
      2'd0:    r = ia + ib;
      2'd1:    r = (ia - ib + 32) % 32;
      2'd2:    r = ia & ib;
      default: r = ia ^ ib;
    endcase
    o.result = 5'(r);
    o.answer = 4'(r % 16);
    o.eq     = (ia == ib);
    o.less   = (ia < ib);
    o.great  = (ia > ib);
    return o;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Behavioural model: phase 0 = free, 1 = computing, 2 = holding a response.
  int       phase = 0;
  bit       m_init = 1'b0;
  bit       m_ptr;
  int       m_cnt0, m_cnt1;
  bit       m_id;
  logic [1:0] m_op;
  logic [3:0] m_a, m_b;
  bit       mg0, mg1;
  alu_out_t me;

  always @(negedge clk) begin
    if (m_init) begin
      mg0 = (phase == 0) && bus.req0_valid && (!bus.req1_valid || !m_ptr);
      mg1 = (phase == 0) && bus.req1_valid && (!bus.req0_valid ||  m_ptr);
      check("ready0", bus.req0_ready, mg0);
      check("ready1", bus.req1_ready, mg1);
      check("rsp_valid", bus.rsp_valid, phase == 2);
      if (phase == 2) begin
        me = alu_ref(m_op, m_a, m_b);
        check("rsp_id", bus.rsp_id, m_id);
        check("rsp_fields", {bus.rsp_result, bus.rsp_answer, bus.rsp_eq, bus.rsp_less, bus.rsp_great}, me);
      end
      check("gnt_cnt0", gnt_cnt0, sat(m_cnt0, 255));
      check("gnt_cnt1", gnt_cnt1, sat(m_cnt1, 255));
      check("sat_cnt0", sat_cnt0, sat(m_cnt0, 3));
      check("sat_cnt1", sat_cnt1, sat(m_cnt1, 3));
    end
    // Inputs are stable from here to the next rising edge, so advance the model now.
    if (rst) begin
      phase  = 0;
      m_ptr  = PRIO_INIT;
      m_cnt0 = 0;
      m_cnt1 = 0;
      m_init = 1'b1;
    end else if (m_init) begin
      if (phase == 0 && (mg0 || mg1)) begin
        m_id  = mg1;
        m_op  = mg1 ? bus.req1_op : bus.req0_op;
        m_a   = mg1 ? bus.req1_a  : bus.req0_a;
        m_b   = mg1 ? bus.req1_b  : bus.req0_b;
        if (mg1) m_cnt1++; else m_cnt0++;
        m_ptr = !mg1;
        phase = 1;
      end else if (phase == 1) begin
        phase = 2;
      end else if (phase == 2 && bus.rsp_ready) begin
        phase = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic rand_payload(input bit id);
    logic [3:0] a;
    a = 4'($urandom_range(0, 15));
    if (id) begin
      bus.req1_op = 2'($urandom_range(0, 3));
      bus.req1_a  = a;
      bus.req1_b  = ($urandom_range(0, 3) == 0) ? a : 4'($urandom_range(0, 15));
    end else begin
      bus.req0_op = 2'($urandom_range(0, 3));
      bus.req0_a  = a;
      bus.req0_b  = ($urandom_range(0, 3) == 0) ? a : 4'($urandom_range(0, 15));
    end
  endtask

  // One complete operation from requester id; the response is taken right away.
  task automatic run_op(input bit id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int n;
    n = 0;
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
    #1;
    while (!(id ? bus.req1_ready : bus.req0_ready) && n < 10) begin
      tick();
      n++;
    end
    check("run_op_accept_wait", n < 10, 1'b1);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    tick();
    tick();
    bus.rsp_ready  = 1'b0;
  endtask

  int glog[$];
  bit r0, r1, x0, x1;
  int n;

  initial begin
    clear_inputs();
    bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;

    // Pin the reference ALU to hand-computed values.
    check("ref_xor", alu_ref(2'b11, 4'b1110, 4'b0011), 12'b01101_1101_001);
    check("ref_and", alu_ref(2'b10, 4'b1010, 4'b1010), 12'b01010_1010_100);
    check("ref_add", alu_ref(2'b00, 4'b1111, 4'b0001), 12'b10000_0000_001);
    check("ref_sub", alu_ref(2'b01, 4'b0011, 4'b0101), 12'b11110_1110_010);

    // Reset state.
    do_reset();
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_all", {bus.rsp_id, bus.rsp_result, bus.rsp_answer, bus.rsp_eq, bus.rsp_less, bus.rsp_great}, 0);
    check("rst_cnts", {gnt_cnt0, gnt_cnt1, sat_cnt0, sat_cnt1}, 0);

    // Single op from requester 0: ready in cycle 0, response in cycle 2.
    bus.req0_valid = 1'b1; bus.req0_op = 2'b11; bus.req0_a = 4'b1110; bus.req0_b = 4'b0011;
    #1;
    check("t1_ready0", bus.req0_ready, 1'b1);
    tick();
    bus.req0_valid = 1'b0;
    check("t1_exec_no_rsp", bus.rsp_valid, 1'b0);
    tick();
    check("t1_rsp_valid", bus.rsp_valid, 1'b1);
    check("t1_rsp_id", bus.rsp_id, 1'b0);
    check("t1_result", bus.rsp_result, 5'b01101);
    check("t1_answer", bus.rsp_answer, 4'b1101);
    check("t1_flags", {bus.rsp_eq, bus.rsp_less, bus.rsp_great}, 3'b001);
    check("t1_cnt0", gnt_cnt0, 8'd1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // Backpressure: pointer now favours requester 1; requester 0 keeps asking throughout.
    bus.req1_valid = 1'b1; bus.req1_op = 2'b10; bus.req1_a = 4'b1010; bus.req1_b = 4'b1010;
    bus.req0_valid = 1'b1; bus.req0_op = 2'b00; bus.req0_a = 4'd3; bus.req0_b = 4'd4;
    #1;
    check("t3_grant1", {bus.req1_ready, bus.req0_ready}, 2'b10);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", bus.rsp_valid, 1'b1);
      check("t3_hold_fields", {bus.rsp_id, bus.rsp_result, bus.rsp_eq, bus.rsp_less, bus.rsp_great}, 9'b1_01010_100);
      check("t3_no_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("t3_released", bus.rsp_valid, 1'b0);
    check("t3_idle_ready0", bus.req0_ready, 1'b1);
    tick();
    bus.req0_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    tick();
    tick();
    tick();
    bus.rsp_ready  = 1'b0;

    // Contention from reset: grants alternate starting with requester 0.
    do_reset();
    glog.delete();
    bus.rsp_ready = 1'b1;
    rand_payload(0); rand_payload(1);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    n = 0;
    while (glog.size() < 4 && n < 40) begin
      #1;
      r0 = bus.req0_ready;
      r1 = bus.req1_ready;
      tick();
      n++;
      if (r0) begin glog.push_back(0); rand_payload(0); end
      if (r1) begin glog.push_back(1); rand_payload(1); end
      if (glog.size() >= 4) begin bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; end
    end
    check("t2_four_grants", glog.size(), 4);
    foreach (glog[i]) check("t2_order", glog[i], i % 2);
    check("t2_cnt0", gnt_cnt0, 8'd2);
    check("t2_cnt1", gnt_cnt1, 8'd2);
    tick(); tick(); tick();
    bus.rsp_ready = 1'b0;

    // Lone requester 1 with pointer at 0; priority then returns to requester 0.
    do_reset();
    bus.req1_valid = 1'b1; rand_payload(1);
    #1;
    check("t4_lone1", {bus.req1_ready, bus.req0_ready}, 2'b10);
    tick();
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    tick(); tick();
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; rand_payload(0); rand_payload(1);
    #1;
    check("t4_then0", {bus.req1_ready, bus.req0_ready}, 2'b01);
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    tick(); tick();
    bus.rsp_ready  = 1'b0;

    // Reset while executing: operation dropped, pointer back to its reset holder.
    bus.req0_valid = 1'b1; rand_payload(0);
    #1;
    check("t5_accept0", bus.req0_ready, 1'b1);
    tick();
    bus.req0_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t5_no_rsp", bus.rsp_valid, 1'b0);
      tick();
    end
    check("t5_cnts", {gnt_cnt0, gnt_cnt1}, 16'd0);
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    check("t5_prio_init", {bus.req1_ready, bus.req0_ready}, 2'b01);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

    // Saturation: five ops from requester 0.
    do_reset();
    for (int i = 0; i < 5; i++) run_op(1'b0, 2'($urandom_range(0, 3)), 4'(i), 4'(i + 3));
    check("t6_sat_cnt0", sat_cnt0, 2'd3);
    check("t6_wide_cnt0", gnt_cnt0, 8'd5);

    // Randomized traffic; the model process does the checking.
    do_reset();
    x0 = 1'b0; x1 = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (bus.req0_valid && !x0) begin
        if ($urandom_range(0, 15) == 0) bus.req0_valid = 1'b0;
      end else begin
        bus.req0_valid = ($urandom_range(0, 2) != 0);
        rand_payload(0);
      end
      if (bus.req1_valid && !x1) begin
        if ($urandom_range(0, 15) == 0) bus.req1_valid = 1'b0;
      end else begin
        bus.req1_valid = ($urandom_range(0, 2) != 0);
        rand_payload(1);
      end
      bus.rsp_ready = ($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 199) == 0);
      #1;
      x0 = bus.req0_valid && bus.req0_ready;
      x1 = bus.req1_valid && bus.req1_ready;
      tick();
    end
    rst = 1'b0;
    clear_inputs();
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
